xorshift_stream_checker: RTL and testbench

// - Receiving end of the random-number output stream (out_valid/rand_num) produced by the clk3 read side.
// - Takes one frame of NUM_WORDS xorshift32 words and inverts the first word to recover the originating seed.
// - Checks every later word against xorshift32(previous word), then reports seed, pass/fail and error count.
// - Used as an in-system self-check and as the bench scoreboard; synthesizable, single clock domain.

---
 rtl/xs32_pkg.sv | 29 ++
 rtl/xorshift_stream_checker_if.sv | 24 ++
 rtl/xs32_frame_cnt.sv | 54 +++++
 rtl/xorshift_stream_checker.sv | 113 +++++++++++
 tb/tb_xorshift_stream_checker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/xs32_pkg.sv
// Shared xorshift32 step/inverse functions and the checker state encoding.
// Pure combinational helpers; no state, no handshake.
package xs32_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } state_t;

  function automatic logic [31:0] xs32_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Each xorshift stage is undone in reverse order; the left-shift stages need
  // the full geometric series of shifts because their shift is below 16.
  function automatic logic [31:0] xs32_prev(input logic [31:0] y);
    logic [31:0] t;
    t = y ^ (y << 5) ^ (y << 10) ^ (y << 15) ^ (y << 20) ^ (y << 25) ^ (y << 30);
    t = t ^ (t >> 17);
    t = t ^ (t << 13) ^ (t << 26);
    return t;
  endfunction

endpackage

// File: rtl/xorshift_stream_checker_if.sv
// Stream input (valid + word, no ready) and report outputs of the checker.
// Latency and backpressure are defined by the checker; this is wiring only.
interface xorshift_stream_checker_if #(
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic [31:0]      rand_num;
  logic             busy;
  logic             out_valid;
  logic [31:0]      seed_out;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic             timeout;

  modport master (
    output in_valid, rand_num,
    input  busy, out_valid, seed_out, pass, err_cnt, timeout
  );

  modport slave (
    input  in_valid, rand_num,
    output busy, out_valid, seed_out, pass, err_cnt, timeout
  );
endinterface

// File: rtl/xs32_frame_cnt.sv
// Word and idle-cycle counters for one frame; flags are combinational from the counters.
// last_word_o means the next accepted word completes the frame; no backpressure.
module xs32_frame_cnt #(
  parameter int NUM_WORDS = 256,
  parameter int TIMEOUT   = 1023,
  parameter int CNT_W     = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic start_i,
  input  logic word_i,
  input  logic idle_i,
  output logic last_word_o,
  output logic idle_expired_o
);

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (clr_i) begin
      word_cnt_d = '0;
      idle_cnt_d = '0;
    end else if (start_i) begin
      word_cnt_d = CNT_W'(1);
      idle_cnt_d = '0;
    end else if (word_i) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      idle_cnt_d = '0;
    end else if (idle_i && (idle_cnt_q != '1)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Expiry fires on the idle cycle that brings the count up to TIMEOUT.
  assign last_word_o    = (word_cnt_q == CNT_W'(NUM_WORDS - 1));
  assign idle_expired_o = (TIMEOUT != 0) && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

endmodule

// File: rtl/xorshift_stream_checker.sv
// Recovers the seed of an xorshift32 frame and checks its chain; report strobe 1 cycle after the last word.
// No backpressure: the stream cannot be stalled, and a word arriving in the report cycle is dropped.
module xorshift_stream_checker
  import xs32_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int TIMEOUT   = 1023,
  parameter int CNT_W     = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  xorshift_stream_checker_if.slave   bus
);

  state_t           state_q;
  logic [31:0]      prev_q;
  logic [31:0]      seed_q;
  logic [CNT_W-1:0] err_q, err_d;
  logic             busy_q, vld_q, pass_q, to_q;

  logic accept_first, accept_word, idle_tick, mismatch;
  logic last_word, idle_expired;

  assign accept_first = (state_q == IDLE) && bus.in_valid;
  assign accept_word  = (state_q == RECV) && bus.in_valid;
  assign idle_tick    = (state_q == RECV) && !bus.in_valid;
  assign mismatch     = (bus.rand_num != xs32_next(prev_q));

  xs32_frame_cnt #(
    .NUM_WORDS (NUM_WORDS),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_frame_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (state_q == REPORT),
    .start_i        (accept_first),
    .word_i         (accept_word),
    .idle_i         (idle_tick),
    .last_word_o    (last_word),
    .idle_expired_o (idle_expired)
  );

  // err_cnt is held after the report and only cleared when the next frame starts.
  always_comb begin
    err_d = err_q;
    if (accept_first) begin
      err_d = '0;
    end else if (accept_word && mismatch && (err_q != '1)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          vld_q  <= 1'b0;
          pass_q <= 1'b0;
          to_q   <= 1'b0;
          if (bus.in_valid) begin
            prev_q  <= bus.rand_num;
            seed_q  <= xs32_prev(bus.rand_num);
            busy_q  <= 1'b1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (bus.in_valid) begin
            // Chain from the received word so one bad word costs exactly two errors.
            prev_q <= bus.rand_num;
            if (last_word) begin
              state_q <= REPORT;
              vld_q   <= 1'b1;
              pass_q  <= (err_d == '0);
            end
          end else if (idle_expired) begin
            state_q <= REPORT;
            vld_q   <= 1'b1;
            to_q    <= 1'b1;
            pass_q  <= 1'b0;
          end
        end
        REPORT: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          pass_q  <= 1'b0;
          to_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = vld_q;
  assign bus.seed_out  = seed_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Directed bench for xorshift_stream_checker: default instance plus a TIMEOUT=16 instance on the same stream.
module tb_xorshift_stream_checker;

  localparam int NW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xorshift_stream_checker_if #(.CNT_W(9)) xif ();
  xorshift_stream_checker_if #(.CNT_W(9)) xif_to ();

  assign xif_to.in_valid = xif.in_valid;
  assign xif_to.rand_num = xif.rand_num;

  xorshift_stream_checker #(.NUM_WORDS(NW), .TIMEOUT(1023), .CNT_W(9)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (xif)
  );

  xorshift_stream_checker #(.NUM_WORDS(NW), .TIMEOUT(16), .CNT_W(9)) u_dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (xif_to)
  );

  int checks     = 0;
  int errors     = 0;
  int rep_cnt    = 0;
  int busy_drops = 0;
  bit mon_busy   = 1'b0;

  always @(negedge clk) begin
    if (xif.out_valid === 1'b1) rep_cnt++;
  end

  function automatic logic [31:0] model_next(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ (x << 13);
    a = a ^ (a >> 17);
    a = a ^ (a << 5);
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    if (mon_busy && (xif.busy !== 1'b1)) busy_drops++;
    xif.in_valid = v;
    xif.rand_num = d;
  endtask

  task automatic send_frame(input logic [31:0] seed, input int max_gap, input int bad_idx,
                            input int n_words, input bit watch);
    logic [31:0] w;
    w = seed;
    for (int i = 1; i <= n_words; i++) begin
      w = model_next(w);
      if (i > 1) repeat ($urandom_range(max_gap, 0)) drive(1'b0, 32'h0);
      drive(1'b1, (i == bad_idx) ? (w ^ 32'h1) : w);
      if (i == 1) mon_busy = watch;
    end
  endtask

  // Call at the negedge right after the last word was accepted.
  task automatic check_report(input string tag, input logic [31:0] seed,
                              input logic exp_pass, input logic [31:0] exp_err);
    check({tag, " out_valid"}, 32'(xif.out_valid), 32'd1);
    check({tag, " seed_out"},  xif.seed_out,        seed);
    check({tag, " pass"},      32'(xif.pass),      32'(exp_pass));
    check({tag, " err_cnt"},   32'(xif.err_cnt),   exp_err);
    check({tag, " timeout"},   32'(xif.timeout),   32'd0);
    check({tag, " busy"},      32'(xif.busy),      32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rep_before;
    xif.in_valid = 1'b0;
    xif.rand_num = 32'h0;

    #12;
    check("rst busy",      32'(xif.busy),      32'd0);
    check("rst out_valid", 32'(xif.out_valid), 32'd0);
    check("rst pass",      32'(xif.pass),      32'd0);
    check("rst timeout",   32'(xif.timeout),   32'd0);
    check("rst seed_out",  xif.seed_out,       32'd0);
    check("rst err_cnt",   32'(xif.err_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 32'h0);

    // Seed 1 back-to-back; first stream word is 0x00042021.
    drive(1'b1, 32'h0004_2021);
    mon_busy = 1'b0;
    begin
      logic [31:0] w;
      w = 32'h0004_2021;
      for (int i = 2; i <= NW; i++) begin
        w = model_next(w);
        drive(1'b1, w);
      end
    end
    drive(1'b0, 32'h0);
    check_report("seed1", 32'h1, 1'b1, 32'd0);
    drive(1'b0, 32'h0);
    check("seed1 post busy",      32'(xif.busy),      32'd0);
    check("seed1 post out_valid", 32'(xif.out_valid), 32'd0);
    check("seed1 post pass",      32'(xif.pass),      32'd0);
    check("seed1 seed hold",      xif.seed_out,       32'h1);
    repeat (3) drive(1'b0, 32'h0);

    // Seed 0xDEADBEEF with random gaps; busy must stay high throughout.
    send_frame(32'hDEAD_BEEF, 5, 0, NW, 1'b1);
    drive(1'b0, 32'h0);
    mon_busy = 1'b0;
    check_report("gaps", 32'hDEAD_BEEF, 1'b1, 32'd0);
    check("gaps busy drops", 32'(busy_drops), 32'd0);
    drive(1'b0, 32'h0);
    check("gaps post busy", 32'(xif.busy), 32'd0);
    repeat (3) drive(1'b0, 32'h0);

    // Seed 5 with word 100 corrupted: that word and the next both mismatch.
    send_frame(32'h5, 0, 100, NW, 1'b0);
    drive(1'b0, 32'h0);
    check_report("corrupt", 32'h5, 1'b0, 32'd2);
    drive(1'b0, 32'h0);
    check("corrupt err hold", 32'(xif.err_cnt), 32'd2);
    repeat (3) drive(1'b0, 32'h0);

    // Two frames separated by exactly one idle cycle.
    send_frame(32'h1, 0, 0, NW, 1'b0);
    drive(1'b0, 32'h0);
    check_report("pair1", 32'h1, 1'b1, 32'd0);
    send_frame(32'h2, 0, 0, NW, 1'b0);
    drive(1'b0, 32'h0);
    check_report("pair2", 32'h2, 1'b1, 32'd0);
    repeat (3) drive(1'b0, 32'h0);

    // Stream stops after 40 words; only the TIMEOUT=16 instance reports.
    send_frame(32'h9, 0, 0, 40, 1'b0);
    n = 0;
    do begin
      drive(1'b0, 32'h0);
      n++;
    end while ((xif_to.out_valid !== 1'b1) && (n < 100));
    check("to idle cycles", 32'(n - 1), 32'd16);
    check("to timeout",     32'(xif_to.timeout),   32'd1);
    check("to pass",        32'(xif_to.pass),      32'd0);
    check("to seed_out",    xif_to.seed_out,       32'h9);
    check("to err_cnt",     32'(xif_to.err_cnt),   32'd0);
    check("to main no rep", 32'(xif.out_valid),    32'd0);
    check("to main busy",   32'(xif.busy),         32'd1);
    drive(1'b0, 32'h0);
    check("to post timeout", 32'(xif_to.timeout), 32'd0);
    check("to post busy",    32'(xif_to.busy),    32'd0);

    // Reset mid-frame aborts silently; the following frame is clean.
    rep_before = rep_cnt;
    send_frame(32'h3, 0, 0, 128, 1'b0);
    @(negedge clk);
    xif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort busy",     32'(xif.busy),    32'd0);
    check("abort seed_out", xif.seed_out,     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 32'h0);
    send_frame(32'h7, 0, 0, NW, 1'b0);
    drive(1'b0, 32'h0);
    check_report("seed7", 32'h7, 1'b1, 32'd0);
    repeat (4) drive(1'b0, 32'h0);
    check("abort one report", 32'(rep_cnt - rep_before), 32'd1);
    check("total reports",    32'(rep_cnt),             32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
